// File: rtl/eth_phy_link_monitor_if.sv
// rtl/eth_phy_link_monitor_if.sv - PHY status / link monitor signal bundle
//
// Purpose: groups the PHY RX status strobes, the counter clear and the link
// monitor results into one bundle.
// Ports (modport view):
//   master : drives rx_block_lock, rx_high_ber, rx_error_count, rx_bad_block,
//            rx_sequence_error, cnt_clear; observes all monitor outputs
//   slave  : the monitor; consumes the status strobes and drives link_up,
//            link_state, link_change, err_count, bad_block_count,
//            seq_err_count, link_down_count
interface eth_phy_link_monitor_if #(
  parameter int COUNT_WIDTH = 32,
  parameter int LDN_WIDTH   = 16
);
  logic                   rx_block_lock;
  logic                   rx_high_ber;
  logic [6:0]             rx_error_count;
  logic                   rx_bad_block;
  logic                   rx_sequence_error;
  logic                   cnt_clear;
  logic                   link_up;
  logic [1:0]             link_state;
  logic                   link_change;
  logic [COUNT_WIDTH-1:0] err_count;
  logic [COUNT_WIDTH-1:0] bad_block_count;
  logic [COUNT_WIDTH-1:0] seq_err_count;
  logic [LDN_WIDTH-1:0]   link_down_count;

  modport master (
    output rx_block_lock, rx_high_ber, rx_error_count, rx_bad_block,
           rx_sequence_error, cnt_clear,
    input  link_up, link_state, link_change, err_count, bad_block_count,
           seq_err_count, link_down_count
  );

  modport slave (
    input  rx_block_lock, rx_high_ber, rx_error_count, rx_bad_block,
           rx_sequence_error, cnt_clear,
    output link_up, link_state, link_change, err_count, bad_block_count,
           seq_err_count, link_down_count
  );
endinterface

// File: rtl/eth_phy_link_monitor.sv
// rtl/eth_phy_link_monitor.sv - 10G PHY link qualification FSM and event counters
//
// Purpose: debounces PHY block lock / high-BER into a qualified link_up via a
// DOWN/QUALIFY/UP FSM, and keeps saturating counters of PHY error events.
// Ports:
//   clk  : PHY RX clock
//   rst  : synchronous, active-high reset
//   bus  : eth_phy_link_monitor_if.slave (status strobes in, link status and
//          counters out)
module eth_phy_link_monitor #(
  parameter int COUNT_WIDTH    = 32,
  parameter int LDN_WIDTH      = 16,
  parameter int LINK_UP_CYCLES = 156250
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_phy_link_monitor_if.slave  bus
);

  localparam int TW = (LINK_UP_CYCLES > 2) ? $clog2(LINK_UP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LINK_UP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_UP      = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   link_up_q, link_up_d;
  logic                   link_change_q, link_change_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d;
  logic [COUNT_WIDTH-1:0] bad_q, bad_d;
  logic [COUNT_WIDTH-1:0] seq_q, seq_d;
  logic [LDN_WIDTH-1:0]   ldn_q, ldn_d;

  logic                   good;
  logic                   link_drop;
  logic [COUNT_WIDTH:0]   err_sum;

  assign good = bus.rx_block_lock & ~bus.rx_high_ber;

  // FSM next state; the timer counts good cycles already seen while qualifying
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_DOWN: begin
        if (good) begin
          state_d = ST_QUALIFY;
          timer_d = TW'(1);
        end
      end
      ST_QUALIFY: begin
        if (!good) begin
          state_d = ST_DOWN;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_UP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_UP: begin
        if (!good) begin
          state_d = ST_DOWN;
        end
      end
      default: begin
        state_d = ST_DOWN;
        timer_d = '0;
      end
    endcase
  end

  // link_up mirrors the registered state, so it is computed from state_d
  always_comb begin
    link_up_d     = (state_d == ST_UP);
    link_change_d = link_up_d ^ link_up_q;
    link_drop     = (state_q == ST_UP) && (state_d == ST_DOWN);
  end

  // Saturating counters: the extra carry bit of err_sum flags overflow
  always_comb begin
    err_sum = {1'b0, err_q} + {{(COUNT_WIDTH - 6){1'b0}}, bus.rx_error_count};
    err_d   = err_sum[COUNT_WIDTH] ? '1 : err_sum[COUNT_WIDTH-1:0];
    bad_d   = bad_q;
    seq_d   = seq_q;
    ldn_d   = ldn_q;
    if (bus.rx_bad_block && !(&bad_q)) begin
      bad_d = bad_q + COUNT_WIDTH'(1);
    end
    if (bus.rx_sequence_error && !(&seq_q)) begin
      seq_d = seq_q + COUNT_WIDTH'(1);
    end
    if (link_drop && !(&ldn_q)) begin
      ldn_d = ldn_q + LDN_WIDTH'(1);
    end
    // Clear wins over any event sampled in the same cycle
    if (bus.cnt_clear) begin
      err_d = '0;
      bad_d = '0;
      seq_d = '0;
      ldn_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_DOWN;
      timer_q       <= '0;
      link_up_q     <= 1'b0;
      link_change_q <= 1'b0;
      err_q         <= '0;
      bad_q         <= '0;
      seq_q         <= '0;
      ldn_q         <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      link_up_q     <= link_up_d;
      link_change_q <= link_change_d;
      err_q         <= err_d;
      bad_q         <= bad_d;
      seq_q         <= seq_d;
      ldn_q         <= ldn_d;
    end
  end

  assign bus.link_up         = link_up_q;
  assign bus.link_state      = state_q;
  assign bus.link_change     = link_change_q;
  assign bus.err_count       = err_q;
  assign bus.bad_block_count = bad_q;
  assign bus.seq_err_count   = seq_q;
  assign bus.link_down_count = ldn_q;

endmodule

// File: tb/tb_eth_phy_link_monitor.sv
// tb/tb_eth_phy_link_monitor.sv - self-checking bench for eth_phy_link_monitor
module tb_eth_phy_link_monitor;

  localparam int LUC  = 8;
  localparam int CMAX = 255;
  localparam int LMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  eth_phy_link_monitor_if #(.COUNT_WIDTH(8), .LDN_WIDTH(4)) bus ();

  eth_phy_link_monitor #(
    .COUNT_WIDTH(8),
    .LDN_WIDTH(4),
    .LINK_UP_CYCLES(LUC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: link is up after a run of at least LUC consecutive good
  // cycles; counters are plain integers clamped at their maximum.
  int m_run, m_err, m_bb, m_seq, m_ldn;
  bit m_up, m_chg;

  logic [31:0] obs_vec;
  assign obs_vec = {bus.link_up, bus.link_state, bus.link_change, bus.err_count,
                    bus.bad_block_count, bus.seq_err_count, bus.link_down_count};

  function automatic logic [31:0] exp_vec();
    logic [1:0] st;
    st = m_up ? 2'd2 : ((m_run > 0) ? 2'd1 : 2'd0);
    return {m_up, st, m_chg, 8'(m_err), 8'(m_bb), 8'(m_seq), 4'(m_ldn)};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_update();
    bit good, prev;
    if (rst) begin
      m_run = 0; m_up = 0; m_chg = 0;
      m_err = 0; m_bb = 0; m_seq = 0; m_ldn = 0;
    end else begin
      good  = bus.rx_block_lock && !bus.rx_high_ber;
      prev  = m_up;
      m_run = good ? sat(m_run + 1, LUC) : 0;
      m_up  = (m_run >= LUC);
      m_chg = (m_up != prev);
      if (bus.cnt_clear) begin
        m_err = 0; m_bb = 0; m_seq = 0; m_ldn = 0;
      end else begin
        m_err = sat(m_err + int'(bus.rx_error_count), CMAX);
        m_bb  = sat(m_bb + int'(bus.rx_bad_block), CMAX);
        m_seq = sat(m_seq + int'(bus.rx_sequence_error), CMAX);
        if (prev && !m_up) m_ldn = sat(m_ldn + 1, LMAX);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit lock, input bit ber, input int ec,
                        input bit bad, input bit seq, input bit clr);
    bus.rx_block_lock     = lock;
    bus.rx_high_ber       = ber;
    bus.rx_error_count    = 7'(ec);
    bus.rx_bad_block      = bad;
    bus.rx_sequence_error = seq;
    bus.cnt_clear         = clr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_vec !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %h want 00000000", obs_vec);
    end
  endtask

  task automatic test_qualify();
    int pulses = 0;
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      pulses += int'(bus.link_change);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL qualify_cycle%0d: got %h want %h", k, obs_vec, exp_vec());
      end
      if (k == 7 || k == 8) begin
        n_checks++;
        if (bus.link_up !== (k == 8)) begin
          n_errors++;
          $display("FAIL qualify_edge_cycle%0d: got %b want %b", k, bus.link_up, k == 8);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL qualify_change_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_requalify();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    repeat (5) tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (bus.link_state !== 2'd0) begin
      n_errors++;
      $display("FAIL requalify_down: got %0d want 0", bus.link_state);
    end
    set_in(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if (obs_vec !== exp_vec() || bus.link_up !== (k >= 8)) begin
        n_errors++;
        $display("FAIL requalify_cycle%0d: got %h want %h up %b", k, obs_vec, exp_vec(), k >= 8);
      end
    end
    n_checks++;
    if (bus.link_down_count !== 4'd0) begin
      n_errors++;
      $display("FAIL requalify_ldn: got %0d want 0", bus.link_down_count);
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    repeat (LUC + 2) tick();
    set_in(1, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({bus.link_up, bus.link_change, bus.link_down_count} !== {1'b0, 1'b1, 4'd1}) begin
      n_errors++;
      $display("FAIL drop_ber: got up=%b chg=%b ldn=%0d want up=0 chg=1 ldn=1",
               bus.link_up, bus.link_change, bus.link_down_count);
    end
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (obs_vec !== exp_vec() || bus.link_change !== 1'b0 || bus.link_state !== 2'd1) begin
      n_errors++;
      $display("FAIL drop_after: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_saturation();
    int want [4] = '{100, 200, 255, 255};
    do_reset();
    set_in(0, 0, 100, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (bus.err_count !== 8'(want[k]) || obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL err_sat_step%0d: got %0d want %0d", k, bus.err_count, want[k]);
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_clear();
    do_reset();
    set_in(0, 0, 0, 1, 0, 0);
    repeat (3) tick();
    n_checks++;
    if (bus.bad_block_count !== 8'd3) begin
      n_errors++;
      $display("FAIL clear_pre: got %0d want 3", bus.bad_block_count);
    end
    set_in(0, 0, 0, 1, 0, 1);
    tick();
    n_checks++;
    if (bus.bad_block_count !== 8'd0) begin
      n_errors++;
      $display("FAIL clear_wins: got %0d want 0", bus.bad_block_count);
    end
    set_in(0, 0, 0, 1, 0, 0);
    tick();
    n_checks++;
    if (bus.bad_block_count !== 8'd1 || obs_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL clear_next: got %0d want 1", bus.bad_block_count);
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_up();
    do_reset();
    set_in(1, 0, 3, 1, 1, 0);
    repeat (LUC + 3) tick();
    n_checks++;
    if (obs_vec !== exp_vec() || bus.link_up !== 1'b1 || bus.err_count === 8'd0) begin
      n_errors++;
      $display("FAIL mid_up_pre: got %h want %h", obs_vec, exp_vec());
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs_vec !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_up: got %h want 00000000", obs_vec);
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_ldn_saturation();
    do_reset();
    for (int r = 0; r < 17; r++) begin
      set_in(1, 0, 0, 0, 0, 0);
      repeat (LUC) tick();
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL ldn_round%0d: got %h want %h", r, obs_vec, exp_vec());
      end
    end
    n_checks++;
    if (bus.link_down_count !== 4'(LMAX)) begin
      n_errors++;
      $display("FAIL ldn_saturate: got %0d want %0d", bus.link_down_count, LMAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      set_in(($urandom % 16) != 0, ($urandom % 32) == 0,
             (($urandom % 4) == 0) ? int'($urandom % 128) : 0,
             ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 64) == 0);
      rst = (($urandom % 500) == 0);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got %h want %h", k, obs_vec, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    test_reset();
    test_qualify();
    test_requalify();
    test_drop();
    test_saturation();
    test_clear();
    test_reset_mid_up();
    test_ldn_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
